// File: rtl/axis_pkg.sv
// Shared AXI-Stream width constants, arbiter FSM state type and a one-hot
// to index helper used by the round-robin arbiter.
package axis_pkg;

    localparam int AXIS_DATA_W = 16;
    localparam int AXIS_KEEP_W = AXIS_DATA_W / 8;
    localparam int AXIS_ID_W   = 8;
    localparam int MAX_SRC     = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } arb_state_t;

    function automatic logic [2:0] onehot_to_idx(input logic [MAX_SRC-1:0] onehot);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_SRC; i++) begin
            if (onehot[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: returns the first requester found searching
// upward from (last+1) mod N with wrap-around, as a one-hot vector.
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last,
    output logic [N-1:0]     pick,
    output logic             valid
);

    logic             found;
    logic [IDX_W-1:0] idx;

    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = '0;
        // Offset N wraps back to last itself, so it has the lowest priority.
        for (int i = 1; i <= N; i++) begin
            idx = IDX_W'((int'(last) + i) % N);
            if (!found && req[idx]) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end
        end
    end

    assign valid = |req;

endmodule

// File: rtl/axis_rr_arbiter.sv
// Packet-granular round-robin AXI-Stream arbiter: locks onto one source for
// a whole packet and forwards it to the master port with zero latency.
module axis_rr_arbiter
    import axis_pkg::*;
#(
    parameter  int N_SRC  = 4,
    parameter  int DATA_W = AXIS_DATA_W,
    parameter  int ID_W   = AXIS_ID_W,
    localparam int KEEP_W = DATA_W / 8,
    localparam int IDX_W  = $clog2(N_SRC)
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    input  logic [N_SRC-1:0]        S_TVALID,
    output logic [N_SRC-1:0]        S_TREADY,
    input  logic [N_SRC*DATA_W-1:0] S_TDATA,
    input  logic [N_SRC*KEEP_W-1:0] S_TKEEP,
    input  logic [N_SRC*KEEP_W-1:0] S_TSTRB,
    input  logic [N_SRC*ID_W-1:0]   S_TID,
    input  logic [N_SRC-1:0]        S_TLAST,
    output logic                    M_TVALID,
    input  logic                    M_TREADY,
    output logic                    M_TLAST,
    output logic [DATA_W-1:0]       M_TDATA,
    output logic [KEEP_W-1:0]       M_TKEEP,
    output logic [KEEP_W-1:0]       M_TSTRB,
    output logic [ID_W-1:0]         M_TID,
    output logic [IDX_W-1:0]        M_TDEST,
    output logic [N_SRC-1:0]        grant,
    output logic [15:0]             pkt_count
);

    arb_state_t         state_reg, state_next;
    logic [N_SRC-1:0]   grant_reg, grant_next;
    logic [IDX_W-1:0]   gidx_reg, gidx_next;
    logic [IDX_W-1:0]   last_reg, last_next;
    logic [15:0]        pkt_count_reg, pkt_count_next;
    logic               rst_hold_reg;

    logic [N_SRC-1:0]   pick;
    logic               pick_valid;
    logic [MAX_SRC-1:0] pick_wide;

    logic [DATA_W-1:0]  src_data [N_SRC];
    logic [KEEP_W-1:0]  src_keep [N_SRC];
    logic [KEEP_W-1:0]  src_strb [N_SRC];
    logic [ID_W-1:0]    src_id   [N_SRC];

    logic               lock;
    logic               sel_valid;
    logic               sel_last;
    logic               xfer;

    genvar gi;
    generate
        for (gi = 0; gi < N_SRC; gi++) begin : g_unpack
            assign src_data[gi] = S_TDATA[gi*DATA_W +: DATA_W];
            assign src_keep[gi] = S_TKEEP[gi*KEEP_W +: KEEP_W];
            assign src_strb[gi] = S_TSTRB[gi*KEEP_W +: KEEP_W];
            assign src_id[gi]   = S_TID[gi*ID_W +: ID_W];
        end
    endgenerate

    rr_pick #(
        .N     (N_SRC),
        .IDX_W (IDX_W)
    ) u_pick (
        .req   (S_TVALID),
        .last  (last_reg),
        .pick  (pick),
        .valid (pick_valid)
    );

    always_comb begin
        pick_wide              = '0;
        pick_wide[N_SRC-1:0]   = pick;
    end

    assign lock      = (state_reg == ST_LOCK);
    assign sel_valid = S_TVALID[gidx_reg];
    assign sel_last  = S_TLAST[gidx_reg];
    assign xfer      = lock && sel_valid && M_TREADY;

    always_comb begin
        state_next     = state_reg;
        grant_next     = grant_reg;
        gidx_next      = gidx_reg;
        last_next      = last_reg;
        pkt_count_next = pkt_count_reg;
        case (state_reg)
            ST_IDLE: begin
                // The first cycle out of reset never arbitrates.
                if (pick_valid && !rst_hold_reg) begin
                    state_next = ST_LOCK;
                    grant_next = pick;
                    gidx_next  = IDX_W'(onehot_to_idx(pick_wide));
                end
            end
            ST_LOCK: begin
                if (xfer && sel_last) begin
                    state_next     = ST_IDLE;
                    grant_next     = '0;
                    last_next      = gidx_reg;
                    pkt_count_next = pkt_count_reg + 16'd1;
                end
            end
            default: begin
                state_next = ST_IDLE;
                grant_next = '0;
            end
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_reg     <= ST_IDLE;
            grant_reg     <= '0;
            gidx_reg      <= '0;
            last_reg      <= IDX_W'(N_SRC - 1);
            pkt_count_reg <= '0;
            rst_hold_reg  <= 1'b1;
        end else begin
            state_reg     <= state_next;
            grant_reg     <= grant_next;
            gidx_reg      <= gidx_next;
            last_reg      <= last_next;
            pkt_count_reg <= pkt_count_next;
            rst_hold_reg  <= 1'b0;
        end
    end

    always_comb begin
        S_TREADY = '0;
        if (lock) begin
            S_TREADY[gidx_reg] = M_TREADY;
        end
    end

    assign M_TVALID  = lock && sel_valid;
    assign M_TLAST   = lock ? sel_last : 1'b0;
    assign M_TDATA   = lock ? src_data[gidx_reg] : '0;
    assign M_TKEEP   = lock ? src_keep[gidx_reg] : '0;
    assign M_TSTRB   = lock ? src_strb[gidx_reg] : '0;
    assign M_TID     = lock ? src_id[gidx_reg] : '0;
    assign M_TDEST   = lock ? gidx_reg : '0;
    assign grant     = grant_reg;
    assign pkt_count = pkt_count_reg;

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Directed bench for axis_rr_arbiter: a per-source packet generator feeds the
// arbiter and hand-computed grant order, data and counts are compared.
module tb_axis_rr_arbiter;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int KW = 2;
    localparam int IW = 8;

    logic            ACLK = 1'b0;
    logic            ARESET;
    logic [N-1:0]    S_TVALID;
    logic [N-1:0]    S_TREADY;
    logic [N*DW-1:0] S_TDATA;
    logic [N*KW-1:0] S_TKEEP;
    logic [N*KW-1:0] S_TSTRB;
    logic [N*IW-1:0] S_TID;
    logic [N-1:0]    S_TLAST;
    logic            M_TVALID;
    logic            M_TREADY;
    logic            M_TLAST;
    logic [DW-1:0]   M_TDATA;
    logic [KW-1:0]   M_TKEEP;
    logic [KW-1:0]   M_TSTRB;
    logic [IW-1:0]   M_TID;
    logic [1:0]      M_TDEST;
    logic [N-1:0]    grant;
    logic [15:0]     pkt_count;

    int          checks   = 0;
    int          failures = 0;
    int          beat      [N];
    int          plen      [N];
    int          pkts_left [N];
    logic [15:0] base      [N];
    logic [N-1:0] stall;
    logic [15:0] got_q [$];

    axis_rr_arbiter #(.N_SRC(N), .DATA_W(DW), .ID_W(IW)) dut (
        .ACLK      (ACLK),
        .ARESET    (ARESET),
        .S_TVALID  (S_TVALID),
        .S_TREADY  (S_TREADY),
        .S_TDATA   (S_TDATA),
        .S_TKEEP   (S_TKEEP),
        .S_TSTRB   (S_TSTRB),
        .S_TID     (S_TID),
        .S_TLAST   (S_TLAST),
        .M_TVALID  (M_TVALID),
        .M_TREADY  (M_TREADY),
        .M_TLAST   (M_TLAST),
        .M_TDATA   (M_TDATA),
        .M_TKEEP   (M_TKEEP),
        .M_TSTRB   (M_TSTRB),
        .M_TID     (M_TID),
        .M_TDEST   (M_TDEST),
        .grant     (grant),
        .pkt_count (pkt_count)
    );

    always #5 ACLK = ~ACLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive_srcs();
        for (int k = 0; k < N; k++) begin
            S_TVALID[k]          = (pkts_left[k] != 0) && !stall[k];
            S_TDATA[k*DW +: DW]  = base[k] + 16'(beat[k]);
            S_TKEEP[k*KW +: KW]  = 2'(k);
            S_TSTRB[k*KW +: KW]  = ~2'(k);
            S_TID[k*IW +: IW]    = 8'h10 + 8'(k);
            S_TLAST[k]           = (beat[k] == plen[k] - 1);
        end
        #1;
    endtask

    // One clock: note handshakes before the edge, advance the sources after it.
    task automatic cycle();
        logic [N-1:0] fire;
        fire = S_TVALID & S_TREADY;
        @(posedge ACLK);
        #1;
        for (int k = 0; k < N; k++) begin
            if (fire[k]) begin
                if (beat[k] == plen[k] - 1) begin
                    beat[k] = 0;
                    pkts_left[k]--;
                end else begin
                    beat[k]++;
                end
            end
        end
        drive_srcs();
    endtask

    task automatic reset_dut();
        ARESET   = 1'b1;
        M_TREADY = 1'b1;
        stall    = '0;
        for (int k = 0; k < N; k++) begin
            beat[k]      = 0;
            plen[k]      = 1;
            pkts_left[k] = 0;
            base[k]      = '0;
        end
        drive_srcs();
        repeat (2) cycle();
        ARESET = 1'b0;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int d;

        // All four sources stream 3-beat packets; source 0 sends two.
        reset_dut();
        for (int k = 0; k < N; k++) begin
            plen[k]      = 3;
            base[k]      = 16'(k << 8);
            pkts_left[k] = (k == 0) ? 2 : 1;
        end
        drive_srcs();
        check("rst_valid", M_TVALID, 0);
        check("rst_sready", S_TREADY, 0);
        cycle();
        check("rst_grant", grant, 0);
        check("rst_count", pkt_count, 0);
        for (int p = 0; p < 5; p++) begin
            d = p % 4;
            cycle();
            for (int b = 0; b < 3; b++) begin
                check("t1_dest", M_TDEST, d);
                check("t1_data", M_TDATA, (d << 8) + b);
                check("t1_last", M_TLAST, (b == 2) ? 1 : 0);
                check("t1_grant", grant, 1 << d);
                check("t1_sready", S_TREADY, 1 << d);
                if (b == 0) begin
                    check("t1_tid", M_TID, 8'h10 + d);
                    check("t1_keep", M_TKEEP, d);
                    check("t1_strb", M_TSTRB, 3 - d);
                end
                cycle();
            end
            check("t1_bubble", M_TVALID, 0);
            check("t1_count", pkt_count, p + 1);
            $display("pkt %0d src=%0d pkt_count=%0d", p, d, pkt_count);
        end

        // Source 2 alone, 4 beats, with master ready toggling.
        reset_dut();
        plen[2]      = 4;
        base[2]      = 16'h0001;
        pkts_left[2] = 1;
        drive_srcs();
        for (int c = 0; c < 20; c++) begin
            if (M_TVALID && M_TREADY) begin
                got_q.push_back(M_TDATA);
                if (got_q.size() == 1) check("t2_dest", M_TDEST, 2);
            end
            cycle();
            M_TREADY = ~M_TREADY;
            #1;
        end
        check("t2_nbeats", got_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check("t2_beat", got_q[i], i + 1);
        end
        check("t2_count", pkt_count, 1);
        $display("pkt src=2 beats=%0d pkt_count=%0d", got_q.size(), pkt_count);

        // Source 1 stalls mid-packet while source 3 waits.
        reset_dut();
        plen[1] = 4;  base[1] = 16'h0100;  pkts_left[1] = 1;
        plen[3] = 4;  base[3] = 16'h0300;  pkts_left[3] = 1;
        drive_srcs();
        cycle();
        cycle();
        check("t3_grant", grant, 4'b0010);
        check("t3_b0", M_TDATA, 16'h0100);
        cycle();
        check("t3_b1", M_TDATA, 16'h0101);
        cycle();
        stall[1] = 1'b1;
        drive_srcs();
        for (int s = 0; s < 2; s++) begin
            check("t3_stall_valid", M_TVALID, 0);
            check("t3_stall_grant", grant, 4'b0010);
            check("t3_stall_sready", S_TREADY, 4'b0010);
            cycle();
        end
        stall[1] = 1'b0;
        drive_srcs();
        check("t3_b2", M_TDATA, 16'h0102);
        check("t3_b2_valid", M_TVALID, 1);
        cycle();
        check("t3_b3", M_TDATA, 16'h0103);
        check("t3_b3_last", M_TLAST, 1);
        cycle();
        check("t3_idle_grant", grant, 0);
        cycle();
        check("t3_src3_grant", grant, 4'b1000);
        check("t3_src3_data", M_TDATA, 16'h0300);
        repeat (4) cycle();
        check("t3_count", pkt_count, 2);
        $display("pkt src=1,3 pkt_count=%0d", pkt_count);

        // Reset lands on beat 2 of a 5-beat packet from source 3.
        plen[3] = 5;  base[3] = 16'h0500;  pkts_left[3] = 1;
        drive_srcs();
        cycle();
        check("t4_grant", grant, 4'b1000);
        cycle();
        cycle();
        check("t4_b2", M_TDATA, 16'h0502);
        ARESET = 1'b1;
        plen[0] = 2;  pkts_left[0] = 1;
        drive_srcs();
        cycle();
        check("t4_rst_grant", grant, 0);
        check("t4_rst_count", pkt_count, 0);
        check("t4_rst_valid", M_TVALID, 0);
        ARESET = 1'b0;
        #1;
        cycle();
        check("t4_hold_grant", grant, 0);
        cycle();
        check("t4_first_grant", grant, 4'b0001);
        check("t4_first_dest", M_TDEST, 0);
        $display("pkt abandoned src=3 next_grant=%0b", grant);

        // Counter at 0xFFFF, then one single-beat packet wraps it.
        reset_dut();
        force dut.pkt_count_reg = 16'hFFFF;
        cycle();
        cycle();
        release dut.pkt_count_reg;
        #1;
        check("t5_preload", pkt_count, 16'hFFFF);
        plen[1] = 1;  base[1] = 16'hABCD;  pkts_left[1] = 1;
        drive_srcs();
        cycle();
        check("t5_data", M_TDATA, 16'hABCD);
        check("t5_last", M_TLAST, 1);
        cycle();
        check("t5_wrap", pkt_count, 0);
        check("t5_idle", M_TVALID, 0);
        $display("pkt src=1 single-beat pkt_count=%0d", pkt_count);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axis_rr_arbiter.md
AXIS_RR_ARBITER -- requirements
Module: axis_rr_arbiter

Interface
REQ-001 SHALL provide parameter N_SRC, default 4, number of AXI-Stream source ports (2..8).
REQ-002 SHALL provide parameter DATA_W, default 16, TDATA width in bits; TKEEP width is DATA_W/8.
REQ-003 SHALL provide parameter ID_W, default 8, TID width in bits.
REQ-004 SHALL have port ACLK  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port ARESET  input  1  synchronous, active-high reset.
REQ-006 SHALL have port S_TVALID  input  N_SRC  per-source valid.
REQ-007 SHALL have port S_TREADY  output  N_SRC  per-source ready.
REQ-008 SHALL have port S_TDATA  input  N_SRC*DATA_W  packed source data; source k occupies slice k.
REQ-009 SHALL have ports S_TKEEP, S_TSTRB  input  N_SRC*DATA_W/8 each  packed byte qualifiers.
REQ-010 SHALL have port S_TID  input  N_SRC*ID_W  packed stream IDs.
REQ-011 SHALL have port S_TLAST  input  N_SRC  per-source end of packet.
REQ-012 SHALL have ports M_TVALID, M_TLAST  output  1 each; M_TREADY  input  1.
REQ-013 SHALL have ports M_TDATA  output  DATA_W; M_TKEEP, M_TSTRB  output  DATA_W/8 each; M_TID  output  ID_W; M_TDEST  output  clog2(N_SRC)  index of the granted source.
REQ-014 SHALL have port grant  output  N_SRC  one-hot registered grant, all-zero when idle.
REQ-015 SHALL have port pkt_count  output  16  count of completed output packets.

Function
REQ-016 SHALL implement a two-state FSM: IDLE and LOCK.
REQ-017 In IDLE, S_TREADY, M_TVALID, and grant SHALL all be 0.
REQ-018 In IDLE with any S_TVALID high, the FSM SHALL select the first requesting index searching from (last+1) mod N_SRC upward with wrap, register it in grant, and enter LOCK on the next edge.
REQ-019 In LOCK, all M_* outputs SHALL equal the granted source's signals combinationally (zero latency).
REQ-020 In LOCK, S_TREADY[g] SHALL equal M_TREADY and all other S_TREADY bits SHALL be 0.
REQ-021 A beat SHALL transfer only when M_TVALID && M_TREADY are both high.
REQ-022 A transfer with M_TLAST=1 SHALL return the FSM to IDLE, set last=g, and increment pkt_count with wrap 0xFFFF->0.
REQ-023 Grant SHALL be held for a whole packet even if the granted S_TVALID deasserts mid-packet; M_TVALID follows it and no other source is served.
REQ-024 Each arbitration SHALL cost exactly one IDLE bubble cycle between packets; back-to-back beats within a packet SHALL sustain one beat per cycle.
REQ-025 A request raised in the same cycle that the current packet's last beat transfers SHALL only be considered in the following IDLE cycle.
REQ-026 A single-beat packet (TLAST on the first beat) SHALL be handled as a complete packet.

Reset
REQ-027 ARESET SHALL force state=IDLE, grant=0, pkt_count=0, and last=N_SRC-1, so source 0 wins first; this applies mid-packet, and the partial packet is abandoned.
REQ-028 All outputs SHALL hold their idle values during reset, and the first grant SHALL occur no earlier than the second edge after ARESET falls.

Structure
REQ-029 N_SRC-independent AXI-Stream width constants (DATA_W=16, KEEP_W=2, ID_W=8) and the FSM state enum SHALL live in shared package axis_pkg.
REQ-030 The rotating priority search SHALL be a sub-module rr_pick (inputs: request vector and last; output: one-hot pick plus valid).

Verification
REQ-031 After reset, S_TVALID=4'b1111, each source sends a 3-beat packet, M_TREADY=1 -> M_TDEST order 0,1,2,3,0; one bubble between packets; pkt_count increments 1..5.
REQ-032 Source 2 only, TDATA 0x0001..0x0004 with TLAST on 0x0004, M_TREADY toggling 1,0 -> output beats are exactly 0x0001..0x0004 in order; pkt_count=1.
REQ-033 Source 1 holds grant, its S_TVALID drops 2 cycles mid-packet while source 3 requests -> M_TVALID=0 for those 2 cycles, grant stays 4'b0010, and source 3 is served only after source 1's TLAST.
REQ-034 ARESET pulsed during beat 2 of a 5-beat packet from source 3 -> grant=0 and pkt_count=0 on the next edge; the first post-reset grant goes to source 0 when sources 0 and 3 both request.
REQ-035 With pkt_count preloaded by 65535 single-beat packets, one more packet -> pkt_count=0.
